// File: rtl/font_rom_arbiter_pkg.sv
// Shared font ROM field widths, blank glyph codes and the ROM request record.
// Pure declarations: no logic, no latency, no flow control.
package font_rom_arbiter_pkg;

    localparam int FONT_AD_W   = 2;
    localparam int FONT_SEL_W  = 4;
    localparam int FONT_ROW_W  = 4;
    localparam int FONT_DATA_W = 8;

    localparam logic [FONT_AD_W-1:0]  FONT_BLANK_AD  = 2'd1;
    localparam logic [FONT_SEL_W-1:0] FONT_BLANK_SEL = 4'd15;

    localparam logic [FONT_SEL_W-1:0] CHAR_DOTS = 4'd6;
    localparam logic [FONT_SEL_W-1:0] CHAR_BAR  = 4'd3;

    typedef struct packed {
        logic [FONT_AD_W-1:0]  ad;
        logic [FONT_SEL_W-1:0] sel;
        logic [FONT_ROW_W-1:0] row;
    } rom_req_t;

endpackage

// File: rtl/font_rom_arbiter_if.sv
// Requester, ROM and response signals of the font ROM arbiter.
// slave = arbiter side, master = overlay/ROM environment side.
interface font_rom_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    import font_rom_arbiter_pkg::*;

    logic                                  en;
    logic [NUM_REQ-1:0]                    req;
    logic [NUM_REQ-1:0][FONT_AD_W-1:0]     req_ad;
    logic [NUM_REQ-1:0][FONT_SEL_W-1:0]    req_sel;
    logic [NUM_REQ-1:0][FONT_ROW_W-1:0]    req_row;
    logic [NUM_REQ-1:0]                    ack;
    logic [FONT_AD_W-1:0]                  rom_ad;
    logic [FONT_SEL_W-1:0]                 rom_sel;
    logic [FONT_ROW_W-1:0]                 rom_row;
    logic [FONT_DATA_W-1:0]                rom_data;
    logic [NUM_REQ-1:0]                    rsp_valid;
    logic [FONT_DATA_W-1:0]                rsp_data;
    logic                                  busy;

    modport slave (
        input  en, req, req_ad, req_sel, req_row, rom_data,
        output ack, rom_ad, rom_sel, rom_row, rsp_valid, rsp_data, busy
    );

    modport master (
        output en, req, req_ad, req_sel, req_row, rom_data,
        input  ack, rom_ad, rom_sel, rom_row, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/font_rom_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, as one-hot plus index.
// Combinational, zero latency; no backpressure (any_o low when nothing requests).
module font_rom_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int               i;
            logic [IDX_W-1:0] cand;
            i = int'(ptr_i) + k;
            if (i >= NUM_REQ) i = i - NUM_REQ;
            cand = IDX_W'(i);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/font_rom_arbiter.sv
// Shares one font ROM among NUM_REQ overlay requesters, one grant per cycle, round-robin.
// ack is combinational; glyph row returns ROM_LAT+1 cycles after ack; losers simply hold req.
module font_rom_arbiter
    import font_rom_arbiter_pkg::*;
#(
    parameter int                    NUM_REQ   = 4,
    parameter int                    ROM_LAT   = 1,
    parameter logic [FONT_AD_W-1:0]  BLANK_AD  = FONT_BLANK_AD,
    parameter logic [FONT_SEL_W-1:0] BLANK_SEL = FONT_BLANK_SEL
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    font_rom_arbiter_if.slave  bus
);

    localparam int       IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam rom_req_t BLANK_REQ = '{ad: BLANK_AD, sel: BLANK_SEL, row: '0};

    logic [NUM_REQ-1:0]     pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   grant_vld;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    rom_req_t               rom_q, rom_d;
    logic [ROM_LAT-1:0]     tag_vld_q;
    logic [IDX_W-1:0]       tag_id_q [ROM_LAT];
    logic [NUM_REQ-1:0]     rsp_vld_q, rsp_vld_d;
    logic [FONT_DATA_W-1:0] rsp_dat_q, rsp_dat_d;

    font_rom_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i (bus.req),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign grant_vld = bus.en & pick_any;
    assign bus.ack   = grant_vld ? pick_gnt : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        rom_d    = BLANK_REQ;
        if (grant_vld) begin
            rom_d.ad  = bus.req_ad[pick_idx];
            rom_d.sel = bus.req_sel[pick_idx];
            rom_d.row = bus.req_row[pick_idx];
            rr_ptr_d  = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IDX_W'(1);
        end
    end

    // The last tag stage lines up with rom_data; the response register is the final stage.
    always_comb begin
        rsp_vld_d = '0;
        rsp_dat_d = rsp_dat_q;
        if (tag_vld_q[ROM_LAT-1]) begin
            rsp_vld_d[tag_id_q[ROM_LAT-1]] = 1'b1;
            rsp_dat_d                      = bus.rom_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rom_q     <= BLANK_REQ;
            rr_ptr_q  <= '0;
            tag_vld_q <= '0;
            for (int s = 0; s < ROM_LAT; s++) tag_id_q[s] <= '0;
            rsp_vld_q <= '0;
            rsp_dat_q <= '0;
        end else begin
            rom_q        <= rom_d;
            rr_ptr_q     <= rr_ptr_d;
            tag_vld_q[0] <= grant_vld;
            tag_id_q[0]  <= pick_idx;
            for (int s = 1; s < ROM_LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
        end
    end

    assign bus.rom_ad    = rom_q.ad;
    assign bus.rom_sel   = rom_q.sel;
    assign bus.rom_row   = rom_q.row;
    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_data  = rsp_dat_q;
    assign bus.busy      = (|tag_vld_q) | (|rsp_vld_q);

endmodule
